// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: access sizes, FSM states, requester IDs.
package mem_arb_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_DONE,
      WR,
      RMW_RD,
      RMW_MERGE,
      RMW_WR
   } arb_state_e;

   typedef enum logic [1:0] {
      REQ_DBG,
      REQ_DATA,
      REQ_FETCH
   } req_id_e;

   // Half on an odd byte, or a word off a word boundary. Size 11 behaves as word.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == SZ_H) && lo[0]) || (size[1] && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: debug/loader, load/store and fetch ports.
interface mem_arbiter_if;

   logic        dbg_req;
   logic        dbg_we;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;

   logic        data_req;
   logic        data_we;
   logic [1:0]  data_size;
   logic        data_unsigned;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ack;
   logic [31:0] data_rdata;
   logic        data_err;

   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack;
   logic [31:0] fetch_rdata;

   modport master (
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata,
      output data_req, data_we, data_size, data_unsigned, data_addr, data_wdata,
      input  data_ack, data_rdata, data_err,
      output fetch_req, fetch_addr,
      input  fetch_ack, fetch_rdata
   );

   modport slave (
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata,
      input  data_req, data_we, data_size, data_unsigned, data_addr, data_wdata,
      output data_ack, data_rdata, data_err,
      input  fetch_req, fetch_addr,
      output fetch_ack, fetch_rdata
   );

endinterface

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane handling: merges sub-word store data into the old word and
// extracts/extends sub-word loads from a memory word.
module lane_align
   import mem_arb_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   output logic [31:0] merged,
   output logic [31:0] loaded
);

   logic [15:0] shifted;

   // Store merge: only the addressed lanes take the right-aligned store data
   always_comb begin
      merged = rd_word;
      case (size)
         SZ_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
         SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

   // Load extract: shift the lane down, then sign- or zero-extend
   always_comb begin
      shifted = 16'(rd_word >> {lane, 3'b000});
      case (size)
         SZ_B:    loaded = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    loaded = uns ? {16'h0, shifted}      : {{16{shifted[15]}}, shifted};
         default: loaded = rd_word;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: dbg > data > fetch with a fetch anti-starvation
// override, byte->word addressing, read-modify-write sub-word stores and
// load extraction/extension with misalignment errors.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   arb_state_e       state, state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   req_id_e          cur_id, win;
   logic [1:0]       cur_size, cur_lane;
   logic             cur_uns;
   logic [31:0]      cur_wdata;

   logic             elig_dbg, elig_data, elig_fetch, any_gnt;
   logic [31:0]      sel_addr, sel_wdata;
   logic             sel_we, sel_uns, sel_err;
   logic [1:0]       sel_size;
   logic [31:0]      merged, loaded;
   logic             unused_addr_hi;

   // A requester whose ack is high this cycle is finishing and must not be re-granted
   assign elig_dbg   = bus.dbg_req   & ~bus.dbg_ack;
   assign elig_data  = bus.data_req  & ~bus.data_ack;
   assign elig_fetch = bus.fetch_req & ~bus.fetch_ack;
   assign any_gnt    = elig_dbg | elig_data | elig_fetch;

   assign unused_addr_hi = ^sel_addr[31:ADDR_W+2];

   // Pick the winner and mux its request fields
   always_comb begin
      win = REQ_FETCH;
      if (elig_fetch && (starve_cnt == CNT_MAX)) win = REQ_FETCH;
      else if (elig_dbg)                          win = REQ_DBG;
      else if (elig_data)                         win = REQ_DATA;

      sel_addr  = bus.fetch_addr;
      sel_we    = 1'b0;
      sel_size  = SZ_W;
      sel_uns   = 1'b0;
      sel_wdata = '0;
      case (win)
         REQ_DBG: begin
            sel_addr  = bus.dbg_addr;
            sel_we    = bus.dbg_we;
            sel_wdata = bus.dbg_wdata;
         end
         REQ_DATA: begin
            sel_addr  = bus.data_addr;
            sel_we    = bus.data_we;
            sel_size  = bus.data_size;
            sel_uns   = bus.data_unsigned;
            sel_wdata = bus.data_wdata;
         end
         default: ;
      endcase
      sel_err = (win == REQ_DATA) && misaligned(sel_size, sel_addr[1:0]);
   end

   // Next-state logic; a misaligned grant is answered directly from IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_gnt && !sel_err) begin
               if (!sel_we)          state_nxt = RD;
               else if (sel_size[1]) state_nxt = WR;
               else                  state_nxt = RMW_RD;
            end
         end
         RD:        state_nxt = RD_DONE;
         RD_DONE:   state_nxt = IDLE;
         WR:        state_nxt = IDLE;
         RMW_RD:    state_nxt = RMW_MERGE;
         RMW_MERGE: state_nxt = RMW_WR;
         RMW_WR:    state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Starvation counter: non-fetch grants while fetch waits; cleared when fetch wins or leaves
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!bus.fetch_req) begin
         starve_cnt <= '0;
      end else if ((state == IDLE) && any_gnt) begin
         if (win == REQ_FETCH)          starve_cnt <= '0;
         else if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
      end
   end

   lane_align u_lane_align (
      .rd_word (mem_rdata),
      .wdata   (cur_wdata),
      .size    (cur_size),
      .lane    (cur_lane),
      .uns     (cur_uns),
      .merged  (merged),
      .loaded  (loaded)
   );

   // Datapath: capture the grant, drive memory, return data and one-cycle acks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_we          <= 1'b0;
         cur_id          <= REQ_DBG;
         cur_size        <= SZ_W;
         cur_lane        <= 2'b00;
         cur_uns         <= 1'b0;
         cur_wdata       <= '0;
         bus.dbg_ack     <= 1'b0;
         bus.dbg_rdata   <= '0;
         bus.data_ack    <= 1'b0;
         bus.data_rdata  <= '0;
         bus.data_err    <= 1'b0;
         bus.fetch_ack   <= 1'b0;
         bus.fetch_rdata <= '0;
      end else begin
         bus.dbg_ack   <= 1'b0;
         bus.data_ack  <= 1'b0;
         bus.fetch_ack <= 1'b0;
         bus.data_err  <= 1'b0;
         mem_we        <= 1'b0;
         case (state)
            IDLE: begin
               if (any_gnt) begin
                  cur_id    <= win;
                  cur_size  <= sel_size;
                  cur_lane  <= sel_addr[1:0];
                  cur_uns   <= sel_uns;
                  cur_wdata <= sel_wdata;
                  if (sel_err) begin
                     bus.data_ack   <= 1'b1;
                     bus.data_err   <= 1'b1;
                     bus.data_rdata <= '0;
                  end else begin
                     mem_addr <= sel_addr[ADDR_W+1:2];
                     if (sel_we && sel_size[1]) begin
                        mem_wdata <= sel_wdata;
                        mem_we    <= 1'b1;
                     end
                  end
               end
            end
            RD_DONE: begin
               case (cur_id)
                  REQ_DBG: begin
                     bus.dbg_rdata <= mem_rdata;
                     bus.dbg_ack   <= 1'b1;
                  end
                  REQ_DATA: begin
                     bus.data_rdata <= loaded;
                     bus.data_ack   <= 1'b1;
                  end
                  default: begin
                     bus.fetch_rdata <= mem_rdata;
                     bus.fetch_ack   <= 1'b1;
                  end
               endcase
            end
            WR: begin
               if (cur_id == REQ_DBG) bus.dbg_ack  <= 1'b1;
               else                   bus.data_ack <= 1'b1;
            end
            RMW_MERGE: begin
               mem_wdata <= merged;
               mem_we    <= 1'b1;
            end
            RMW_WR: bus.data_ack <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
